timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped 32-bit down-counting timer with interrupt output, sitting on the data-bus side of the `mips` core next to the system bridge. The CPU programs it with sw/lw through a 3-word register window; the block counts down from a preset and raises `irq` toward the CPU's external-interrupt input in one-shot or periodic mode.

## Interface
- `CNT_W`, 32, width of PRESET and COUNT registers (CTRL is always 4 bits wide, zero-extended on read)
- `clk`  input  1  system clock, all state updates on rising edge
- `reset`  input  1  asynchronous, active-low; clears all state
- `addr`  input  2  word offset within window: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped
- `we`  input  1  write strobe, sampled on rising edge
- `wdata`  input  32  write data
- `rdata`  output  32  read data, combinational from `addr`
- `irq`  output  1  interrupt request, level, = irq_flag & CTRL.IM

## Operation
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00), [3] IM. wdata[31:4] ignored; reads return 0 in [31:4].
- PRESET: read/write. COUNT: read-only; writes ignored. Addr 3: reads 0, writes ignored.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT: EN=0 -> IDLE (COUNT holds). Else COUNT > 1: COUNT <= COUNT-1, stay. Else (COUNT is 0 or 1): COUNT <= 0, irq_flag <= 1 -> INT.
  - INT, MODE=01: irq_flag <= 0 -> LOAD.
  - INT, other modes: EN <= 0 -> IDLE; irq_flag stays 1.
- irq_flag cleared by any write to CTRL or PRESET (in addition to auto-reload exit).
- Bus write wins over FSM update of the same register in the same cycle (CTRL write in INT overrides the hardware EN clear).
- CTRL write with EN=0 in any state: next state IDLE.
- PRESET write during CNT: COUNT unaffected; new value used at next LOAD.
- Reset mid-count: immediate return to IDLE, all registers 0, `irq` 0.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state IDLE; `rdata` reflects these (all 0); `irq`=0.
- EN written at edge E0 with PRESET=N: LOAD after E1, COUNT=N after E2, COUNT=1 after E(N+1), `irq` high after E(N+2). N=0 or N=1: `irq` high after E3.
- One-shot: `irq` stays high until a CTRL/PRESET write or IM=0; EN reads 0 from the cycle after entering INT.
- Auto-reload, N>=1: one-cycle `irq` pulse every N+2 cycles; N=0 gives period 3.
- `rdata` zero latency: same-cycle combinational read; a read concurrent with a write returns the old value.
- IM change affects `irq` combinationally (same cycle).

## Structure
- Shared package `timer_pkg`: address offsets (CTRL=0, PRESET=1, COUNT=2), MODE encodings, CTRL bit positions, FSM state enum.
- Single module; no sub-module is natural — decode, registers and FSM fit in one file.

## Test plan
- Reset: drive reset low mid-count with PRESET=5, EN=1 -> all reads 0, `irq`=0, state IDLE immediately; after release, no counting until EN rewritten.
- One-shot: PRESET=5, CTRL=0b1001 at E0 -> COUNT reads 5,4,3,2,1 after E2..E6, `irq` high after E7 and held; CTRL reads 0b1000; write CTRL=0b1000 -> `irq` low next cycle.
- Auto-reload: PRESET=3, CTRL=0b1011 -> `irq` one-cycle pulses every 5 cycles, 4 consecutive pulses checked; COUNT reloads to 3 after each pulse.
- Boundaries: PRESET=0 and PRESET=1 one-shot -> `irq` after E3; PRESET=32'hFFFF_FFFF -> first decrement reads FFFF_FFFE, no wrap.
- Masking and disable: IM=0 one-shot PRESET=2 -> `irq` stays 0 while flag sets; then set IM=1 (write also clears flag) -> `irq` stays 0. EN=0 written at COUNT=3 -> IDLE, COUNT holds 3.
- Collisions: PRESET write to 9 during CNT -> current count unaffected, next reload uses 9; CTRL write EN=1 in INT cycle (mode 00) -> EN reads 1, timer re-enters LOAD; writes to COUNT and addr 3 -> no effect, addr 3 reads 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// register window offsets, CTRL field layout, MODE encodings and FSM states.
package timer_pkg;

  // Word offsets within the 3-word register window (offset 3 is unmapped)
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // CTRL register layout: [0] EN, [2:1] MODE, [3] IM
  localparam int CTRL_W        = 4;
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // MODE encodings; the two unused codes fall back to one-shot behaviour
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // True only for the auto-reload encoding; everything else is one-shot
  function automatic logic is_reload(input logic [CTRL_W-1:0] ctrl);
    return (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit down-counting timer with a CTRL/PRESET/COUNT register window and a
// level interrupt. Bus writes take priority over the FSM's own updates.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               irq_flag_q, irq_flag_d;

  logic               ctrl_wr;
  logic               preset_wr;

  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign preset_wr = we && (addr == ADDR_PRESET);

  // Interrupt is the pending flag gated by the mask bit, no register stage
  assign irq = irq_flag_q & ctrl_q[CTRL_IM_BIT];

  // Next-state logic: FSM updates first, then bus writes override them
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN_BIT]) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN_BIT]) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_ONE) begin
          count_d = count_q - CNT_ONE;
          state_d = ST_CNT;
        end else begin
          // Reaching 1 (or starting at 0) terminates the count
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (is_reload(ctrl_q)) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          // One-shot: self-disable, flag stays pending until software acts
          ctrl_d[CTRL_EN_BIT] = 1'b0;
          state_d             = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ctrl_wr) begin
      ctrl_d     = wdata[CTRL_W-1:0];
      irq_flag_d = 1'b0;
      if (!wdata[CTRL_EN_BIT]) begin
        // Disabling freezes COUNT where it is and parks the FSM
        state_d = ST_IDLE;
        count_d = count_q;
      end else begin
        state_d = state_d;
      end
    end else if (preset_wr) begin
      // New preset only takes effect at the next LOAD
      preset_d   = CNT_W'(wdata);
      irq_flag_d = 1'b0;
    end else begin
      preset_d = preset_d;
    end
  end

  // State and register file, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Zero-latency read mux; CTRL is zero-extended, offset 3 reads as zero
  always_comb begin
    rdata = 32'h0000_0000;
    case (addr)
      ADDR_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: rdata = 32'(preset_q);
      ADDR_COUNT:  rdata = 32'(count_q);
      default:     rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expected values are queued as stimulus
// is applied and popped as the corresponding DUT output is sampled.
module tb_timer_counter;
  import timer_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic        we    = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        irq;

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, expected a queued value", obs);
    end else begin
      e = exp_q.pop_front();
      cmp(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    cmp(tag, v, exp);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    cmp(tag, {31'h0, irq}, {31'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic        seen;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rd_chk("rst_ctrl", ADDR_CTRL, 32'h0);
    rd_chk("rst_preset", ADDR_PRESET, 32'h0);
    rd_chk("rst_count", ADDR_COUNT, 32'h0);
    irq_chk("rst_irq", 1'b0);

    // One-shot, PRESET=5, IM=1
    wr(ADDR_PRESET, 32'd5);
    wr(ADDR_CTRL, 32'h9);
    for (int i = 5; i >= 1; i--) push("os_count", 32'(i));
    step();
    step();
    rd(ADDR_COUNT, v);
    check_pop(v);
    for (int i = 0; i < 4; i++) begin
      step();
      rd(ADDR_COUNT, v);
      check_pop(v);
    end
    irq_chk("os_irq_before", 1'b0);
    step();
    irq_chk("os_irq_set", 1'b1);
    step();
    rd_chk("os_en_cleared", ADDR_CTRL, 32'h8);
    irq_chk("os_irq_held1", 1'b1);
    step();
    irq_chk("os_irq_held2", 1'b1);
    wr(ADDR_CTRL, 32'h8);
    irq_chk("os_irq_cleared", 1'b0);

    // Auto-reload, PRESET=3: pulse every 5 cycles
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'hB);
    for (int k = 1; k <= 20; k++) push("ar_irq", ((k >= 5) && ((k % 5) == 0)) ? 32'd1 : 32'd0);
    for (int k = 1; k <= 20; k++) begin
      step();
      check_pop({31'h0, irq});
      if ((k % 5) == 2) rd_chk("ar_reload", ADDR_COUNT, 32'd3);
    end
    wr(ADDR_CTRL, 32'h0);

    // Boundaries: PRESET=0 and PRESET=1 fire after E3
    for (int p = 0; p <= 1; p++) begin
      wr(ADDR_PRESET, 32'(p));
      wr(ADDR_CTRL, 32'h9);
      step();
      step();
      irq_chk("bnd_irq_e2", 1'b0);
      step();
      irq_chk("bnd_irq_e3", 1'b1);
      wr(ADDR_CTRL, 32'h8);
    end

    // Boundary: maximum preset decrements without wrapping
    wr(ADDR_PRESET, 32'hFFFF_FFFF);
    wr(ADDR_CTRL, 32'h1);
    step();
    step();
    rd_chk("max_load", ADDR_COUNT, 32'hFFFF_FFFF);
    step();
    rd_chk("max_dec", ADDR_COUNT, 32'hFFFF_FFFE);
    wr(ADDR_CTRL, 32'h0);

    // Masked one-shot: flag sets but irq stays low
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      irq_chk("mask_irq_low", 1'b0);
    end
    rd_chk("mask_en_cleared", ADDR_CTRL, 32'h0);
    wr(ADDR_CTRL, 32'h8);
    irq_chk("mask_unmask", 1'b0);
    step();
    irq_chk("mask_unmask2", 1'b0);

    // Disable mid-count at COUNT=3
    wr(ADDR_PRESET, 32'd6);
    wr(ADDR_CTRL, 32'h1);
    repeat (5) step();
    rd_chk("dis_at3", ADDR_COUNT, 32'd3);
    wr(ADDR_CTRL, 32'h0);
    rd_chk("dis_hold", ADDR_COUNT, 32'd3);
    repeat (3) step();
    rd_chk("dis_hold_late", ADDR_COUNT, 32'd3);

    // PRESET write during CNT only affects the next reload
    wr(ADDR_PRESET, 32'd4);
    wr(ADDR_CTRL, 32'hB);
    step();
    step();
    rd_chk("col_load", ADDR_COUNT, 32'd4);
    step();
    rd_chk("col_e3", ADDR_COUNT, 32'd3);
    wr(ADDR_PRESET, 32'd9);
    rd_chk("col_unaffected", ADDR_COUNT, 32'd2);
    step();
    rd_chk("col_e5", ADDR_COUNT, 32'd1);
    step();
    irq_chk("col_irq", 1'b1);
    step();
    step();
    rd_chk("col_new_preset", ADDR_COUNT, 32'd9);
    wr(ADDR_CTRL, 32'h0);

    // CTRL write with EN=1 during INT (one-shot) wins over self-disable
    wr(ADDR_PRESET, 32'd1);
    wr(ADDR_CTRL, 32'h9);
    step();
    step();
    step();
    irq_chk("int_irq", 1'b1);
    wr(ADDR_CTRL, 32'h9);
    rd_chk("int_en_kept", ADDR_CTRL, 32'h9);
    irq_chk("int_flag_cleared", 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!seen) begin
        step();
        if (irq) seen = 1'b1;
      end
    end
    cmp("int_reentry", {31'h0, seen}, 32'd1);
    wr(ADDR_CTRL, 32'h0);

    // Writes to COUNT and the unmapped offset are ignored
    wr(ADDR_COUNT, 32'h0000_1234);
    rd_chk("count_ro", ADDR_COUNT, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd_chk("addr3_zero", 2'd3, 32'h0);
    rd_chk("addr3_preset", ADDR_PRESET, 32'd1);
    rd_chk("addr3_ctrl", ADDR_CTRL, 32'h0);

    // Read concurrent with write returns the old value
    addr  = ADDR_PRESET;
    wdata = 32'd55;
    we    = 1'b1;
    #1;
    cmp("rw_old", rdata, 32'd1);
    @(posedge clk);
    #1;
    we = 1'b0;
    rd_chk("rw_new", ADDR_PRESET, 32'd55);

    // Asynchronous reset mid-count
    wr(ADDR_PRESET, 32'd5);
    wr(ADDR_CTRL, 32'h9);
    repeat (3) step();
    reset = 1'b0;
    #1;
    rd_chk("rmid_ctrl", ADDR_CTRL, 32'h0);
    rd_chk("rmid_preset", ADDR_PRESET, 32'h0);
    rd_chk("rmid_count", ADDR_COUNT, 32'h0);
    irq_chk("rmid_irq", 1'b0);
    reset = 1'b1;
    repeat (4) step();
    rd_chk("rmid_no_count", ADDR_COUNT, 32'h0);
    irq_chk("rmid_irq_after", 1'b0);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
